// File: rtl/aurora_nfc_pkg.sv
// Shared definitions for the Aurora RX buffering and NFC request path.
// The NFC generator uses the same code constants. It keys off the
// almost-full level produced by aurora_rx_fifo_nfc.
package aurora_nfc_pkg;

   // NFC codes sent to the link partner
   localparam logic [15:0] NFC_XOFF = 16'h0100;
   localparam logic [15:0] NFC_XON  = 16'h0000;

   // Default geometry of the receive elastic buffer
   localparam int DEFAULT_DATA_W = 16;
   localparam int DEFAULT_DEPTH  = 512;
   localparam int DEFAULT_AF_ON  = 448;
   localparam int DEFAULT_AF_OFF = 256;

   // Occupancy counters need one extra bit so that "completely full" can be
   // represented alongside the pointer range
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/aurora_rx_fifo_nfc_if.sv
// Bundle of the Aurora user RX stream, the downstream valid/ready stream
// and the buffer status seen by the NFC generator.
// The buffer uses the slave modport. Whatever drives Aurora RX and consumes
// the output stream uses the master modport.
interface aurora_rx_fifo_nfc_if
   import aurora_nfc_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int DEPTH  = DEFAULT_DEPTH
);

   localparam int CNT_W = count_width(DEPTH);

   logic              rx_valid;
   logic [DATA_W-1:0] rx_data;
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic              m_ready;
   logic              fifo_almost_full;
   logic [CNT_W-1:0]  fifo_count;
   logic              overflow;

   modport slave (
      input  rx_valid,
      input  rx_data,
      input  m_ready,
      output m_valid,
      output m_data,
      output fifo_almost_full,
      output fifo_count,
      output overflow
   );

   modport master (
      output rx_valid,
      output rx_data,
      output m_ready,
      input  m_valid,
      input  m_data,
      input  fifo_almost_full,
      input  fifo_count,
      input  overflow
   );

endinterface

// File: rtl/aurora_rx_fifo_nfc_fifo_core.sv
// First-word-fall-through synchronous FIFO core.
// The memory is read combinationally at the read pointer, so the head word
// appears on rd_data as soon as the count goes non-zero.
// Occupancy is a separate up/down counter. The pointers only need to wrap.
// A write into a full FIFO is still accepted when a pop happens in the
// same cycle, because the slot being freed is the slot being written.
module sync_fifo_core
   import aurora_nfc_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int DEPTH  = DEFAULT_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = count_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_req,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_req,
   output logic [DATA_W-1:0] rd_data,
   output logic [CNT_W-1:0]  count,
   output logic [CNT_W-1:0]  count_next,
   output logic              empty,
   output logic              drop
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count_q;
   logic              full;
   logic              push;
   logic              pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign pop   = rd_req && !empty;
   assign push  = wr_req && (!full || pop);
   assign drop  = wr_req && !push;

   // Occupancy after this edge; a simultaneous push and pop leaves it unchanged
   always_comb begin
      count_next = count_q;
      unique case ({push, pop})
         2'b10:   count_next = count_q + CNT_W'(1);
         2'b01:   count_next = count_q - CNT_W'(1);
         default: count_next = count_q;
      endcase
   end

   // Storage array; contents are don't-care after reset so it carries no reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers and occupancy; reset discards everything held in the array
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count_q <= count_next;
      end
   end

   assign rd_data = mem[rd_ptr];
   assign count   = count_q;

endmodule

// File: rtl/aurora_rx_fifo_nfc.sv
// Receive-side elastic buffer between Aurora user RX and the downstream
// consumer. Aurora RX cannot be stalled. The buffer raises a hysteretic
// almost-full level so that the NFC generator sends XOFF/XON in time.
// Beats arriving while the buffer is truly full are dropped, and a sticky
// overflow bit records the drop.
module aurora_rx_fifo_nfc
   import aurora_nfc_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int AF_ON  = DEFAULT_AF_ON,
   parameter int AF_OFF = DEFAULT_AF_OFF
) (
   input  logic                clk,
   input  logic                rst,
   aurora_rx_fifo_nfc_if.slave bus
);

   localparam int CNT_W = count_width(DEPTH);
   localparam logic [CNT_W-1:0] AF_ON_C  = CNT_W'(AF_ON);
   localparam logic [CNT_W-1:0] AF_OFF_C = CNT_W'(AF_OFF);

   logic [DATA_W-1:0] rd_data;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_next;
   logic              empty;
   logic              drop;
   logic              af_q;
   logic              overflow_q;

   sync_fifo_core #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_core (
      .clk        (clk),
      .rst        (rst),
      .wr_req     (bus.rx_valid),
      .wr_data    (bus.rx_data),
      .rd_req     (bus.m_ready),
      .rd_data    (rd_data),
      .count      (count),
      .count_next (count_next),
      .empty      (empty),
      .drop       (drop)
   );

   // Almost-full with hysteresis. It uses the post-edge occupancy so that it
   // changes on the same edge as fifo_count, and it moves only once per
   // threshold crossing, as the NFC edge detector expects.
   always_ff @(posedge clk) begin
      if (rst) begin
         af_q <= 1'b0;
      end else if (count_next >= AF_ON_C) begin
         af_q <= 1'b1;
      end else if (count_next <= AF_OFF_C) begin
         af_q <= 1'b0;
      end
   end

   // Sticky overflow: once a beat is lost, only reset clears the indication
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
      end
   end

   assign bus.m_valid          = !empty;
   assign bus.m_data           = rd_data;
   assign bus.fifo_count       = count;
   assign bus.fifo_almost_full = af_q;
   assign bus.overflow         = overflow_q;

endmodule

// File: tb/tb_aurora_rx_fifo_nfc.sv
// Testbench for aurora_rx_fifo_nfc with DEPTH=16, AF_ON=12 and AF_OFF=4.
// A queue-based reference model follows every cycle. A vector table covers
// reset and the first-word latency. Hand sequences cover the hysteresis,
// full/drop and reset corner cases. A random phase then covers backpressure.
module tb_aurora_rx_fifo_nfc;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 16;
   localparam int AF_ON  = 12;
   localparam int AF_OFF = 4;

   logic clk;
   logic rst;

   int checks;
   int errors;

   logic [DATA_W-1:0] model_q [$];
   bit                model_ovf;
   bit                model_af;

   typedef struct {
      bit                r;
      bit                rv;
      logic [DATA_W-1:0] d;
      bit                mr;
      bit                exp_mv;
      int                exp_cnt;
      bit                exp_af;
      bit                exp_ovf;
      logic [DATA_W-1:0] exp_data;
   } vec_t;

   vec_t vecs [11];

   aurora_rx_fifo_nfc_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   aurora_rx_fifo_nfc #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AF_ON  (AF_ON),
      .AF_OFF (AF_OFF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Compare every visible output against the reference model state
   task automatic checkOutput(input string tag);
      check_value({tag, " m_valid"}, 32'(bus.m_valid), 32'(model_q.size() != 0));
      check_value({tag, " count"}, 32'(bus.fifo_count), 32'(model_q.size()));
      check_value({tag, " almost_full"}, 32'(bus.fifo_almost_full), 32'(model_af));
      check_value({tag, " overflow"}, 32'(bus.overflow), 32'(model_ovf));
      if (model_q.size() != 0) begin
         check_value({tag, " m_data"}, 32'(bus.m_data), 32'(model_q[0]));
      end
   endtask

   // Drive one cycle, advance the model across the edge, then sample #1 later
   task automatic applyStimulus(input bit r, input bit rv, input logic [DATA_W-1:0] d,
                                input bit mr, input string tag);
      bit                hold;
      logic [DATA_W-1:0] held;
      bit                pop;
      bit                push;
      int                cnt;
      rst          = r;
      bus.rx_valid = rv;
      bus.rx_data  = d;
      bus.m_ready  = mr;
      hold = (bus.m_valid === 1'b1) && !mr && !r;
      held = bus.m_data;
      @(posedge clk);
      if (r) begin
         model_q.delete();
         model_ovf = 1'b0;
         model_af  = 1'b0;
      end else begin
         pop  = mr && (model_q.size() > 0);
         push = rv && ((model_q.size() < DEPTH) || pop);
         if (rv && !push) model_ovf = 1'b1;
         if (pop) void'(model_q.pop_front());
         if (push) model_q.push_back(d);
         cnt = model_q.size();
         if (cnt >= AF_ON) model_af = 1'b1;
         else if (cnt <= AF_OFF) model_af = 1'b0;
      end
      #1;
      checkOutput(tag);
      if (hold) begin
         check_value({tag, " stable"}, 32'(bus.m_data), 32'(held));
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      model_ovf = 1'b0;
      model_af  = 1'b0;
      rst          = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = '0;
      bus.m_ready  = 1'b0;

      // Reset for three cycles, one idle cycle, then 1..5 streamed through with m_ready high
      vecs[0]  = '{1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000};
      vecs[1]  = '{1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000};
      vecs[2]  = '{1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000};
      vecs[3]  = '{0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000};
      vecs[4]  = '{0, 1, 16'h0001, 1, 1, 1, 0, 0, 16'h0001};
      vecs[5]  = '{0, 1, 16'h0002, 1, 1, 1, 0, 0, 16'h0002};
      vecs[6]  = '{0, 1, 16'h0003, 1, 1, 1, 0, 0, 16'h0003};
      vecs[7]  = '{0, 1, 16'h0004, 1, 1, 1, 0, 0, 16'h0004};
      vecs[8]  = '{0, 1, 16'h0005, 1, 1, 1, 0, 0, 16'h0005};
      vecs[9]  = '{0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000};
      vecs[10] = '{0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000};

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].r, vecs[i].rv, vecs[i].d, vecs[i].mr, $sformatf("vec%0d", i));
         check_value($sformatf("vec%0d tbl m_valid", i), 32'(bus.m_valid), 32'(vecs[i].exp_mv));
         check_value($sformatf("vec%0d tbl count", i), 32'(bus.fifo_count), 32'(vecs[i].exp_cnt));
         check_value($sformatf("vec%0d tbl almost_full", i), 32'(bus.fifo_almost_full), 32'(vecs[i].exp_af));
         check_value($sformatf("vec%0d tbl overflow", i), 32'(bus.overflow), 32'(vecs[i].exp_ovf));
         if (vecs[i].exp_mv) begin
            check_value($sformatf("vec%0d tbl m_data", i), 32'(bus.m_data), 32'(vecs[i].exp_data));
         end
      end

      // Hysteresis: fill to 11 and then to 12 with no reads
      for (int i = 0; i < 11; i++) applyStimulus(0, 1, 16'(16'h0100 + i), 0, "hyst fill");
      check_value("hyst af at 11", 32'(bus.fifo_almost_full), 32'd0);
      applyStimulus(0, 1, 16'h010B, 0, "hyst fill12");
      check_value("hyst count 12", 32'(bus.fifo_count), 32'd12);
      check_value("hyst af at 12", 32'(bus.fifo_almost_full), 32'd1);
      for (int i = 0; i < 7; i++) applyStimulus(0, 0, 16'h0000, 1, "hyst drain");
      check_value("hyst count 5", 32'(bus.fifo_count), 32'd5);
      check_value("hyst af at 5", 32'(bus.fifo_almost_full), 32'd1);
      applyStimulus(0, 0, 16'h0000, 1, "hyst drain4");
      check_value("hyst af at 4", 32'(bus.fifo_almost_full), 32'd0);
      for (int i = 0; i < 7; i++) applyStimulus(0, 1, 16'(16'h0200 + i), 0, "hyst refill");
      check_value("hyst count 11", 32'(bus.fifo_count), 32'd11);
      check_value("hyst af at 11 rising", 32'(bus.fifo_almost_full), 32'd0);

      // Full, dropped beat, and push with pop while full
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, 16'(16'h0300 + i), 0, "full fill");
      check_value("full count 16", 32'(bus.fifo_count), 32'd16);
      check_value("full no overflow yet", 32'(bus.overflow), 32'd0);
      applyStimulus(0, 1, 16'hDEAD, 0, "full drop");
      check_value("drop overflow", 32'(bus.overflow), 32'd1);
      check_value("drop count", 32'(bus.fifo_count), 32'd16);
      applyStimulus(0, 1, 16'hBEEF, 1, "full push pop");
      check_value("pushpop count", 32'(bus.fifo_count), 32'd16);
      for (int i = 0; i < 15; i++) applyStimulus(0, 0, 16'h0000, 1, "full drain");
      check_value("beef last word", 32'(bus.m_data), 32'hBEEF);
      applyStimulus(0, 0, 16'h0000, 1, "full drain last");
      check_value("drained overflow sticky", 32'(bus.overflow), 32'd1);

      // Reset with nine words held and almost-full low
      for (int i = 0; i < 9; i++) applyStimulus(0, 1, 16'(16'h0400 + i), 0, "mid fill");
      check_value("mid count 9", 32'(bus.fifo_count), 32'd9);
      check_value("mid af 0", 32'(bus.fifo_almost_full), 32'd0);
      applyStimulus(1, 1, 16'h0BAD, 1, "mid reset");
      check_value("mid reset count", 32'(bus.fifo_count), 32'd0);
      check_value("mid reset m_valid", 32'(bus.m_valid), 32'd0);
      check_value("mid reset overflow", 32'(bus.overflow), 32'd0);
      applyStimulus(0, 1, 16'h0A01, 0, "post reset w1");
      check_value("post reset data", 32'(bus.m_data), 32'h0A01);
      applyStimulus(0, 1, 16'h0A02, 1, "post reset w2");
      applyStimulus(0, 0, 16'h0000, 1, "post reset r");
      applyStimulus(0, 0, 16'h0000, 1, "post reset r2");

      // Random bursts and backpressure; odd phases starve the reader to force drops
      for (int i = 0; i < 800; i++) begin
         bit rv;
         bit mr;
         int ready_pct;
         ready_pct = ((i / 100) % 2 == 1) ? 15 : 55;
         rv = ($urandom_range(0, 99) < 65);
         mr = ($urandom_range(0, 99) < ready_pct);
         applyStimulus(0, rv, 16'($urandom), mr, $sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
